// File: rtl/divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, 32 iterations, one-cycle ready pulse on completion.
module divider (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic [1:0]  DIVop,
   input  logic        valid,
   output logic [31:0] result,
   output logic        ready
);

   localparam logic [2:0] S_IDLE  = 3'b001;
   localparam logic [2:0] S_CALC  = 3'b010;
   localparam logic [2:0] S_READY = 3'b100;

   logic [2:0]  state_q,  state_d;
   logic [31:0] dvd_q,    dvd_d;
   logic [31:0] dvs_q,    dvs_d;
   logic [31:0] rem_q,    rem_d;
   logic [4:0]  cnt_q,    cnt_d;
   logic [1:0]  op_q,     op_d;
   logic        qneg_q,   qneg_d;
   logic        rneg_q,   rneg_d;
   logic [31:0] result_q, result_d;
   logic        ready_q,  ready_d;

   logic        sd_s;
   logic        ss_s;
   logic [31:0] dvd_abs_s;
   logic [31:0] dvs_abs_s;
   logic [32:0] rem_sh_s;
   logic        ge_s;
   logic [31:0] sub_s;
   logic [31:0] quo_fix_s;
   logic [31:0] rem_fix_s;

   // Operand magnitudes and signs; DIVop[0]=1 selects the unsigned forms
   always_comb begin
      sd_s      = ~DIVop[0] & dividend[31];
      ss_s      = ~DIVop[0] & divisor[31];
      dvd_abs_s = sd_s ? (32'd0 - dividend) : dividend;
      dvs_abs_s = ss_s ? (32'd0 - divisor)  : divisor;
   end

   // One restoring step: the partial remainder needs a 33rd bit for the compare
   always_comb begin
      rem_sh_s  = {rem_q, dvd_q[31]};
      ge_s      = (rem_sh_s >= {1'b0, dvs_q});
      sub_s     = rem_sh_s[31:0] - dvs_q;
      quo_fix_s = qneg_q ? (32'd0 - dvd_q) : dvd_q;
      rem_fix_s = rneg_q ? (32'd0 - rem_q) : rem_q;
   end

   // Next-state logic; the dividend register doubles as the quotient shift register
   always_comb begin
      state_d  = state_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      ready_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid && !ready_q) begin
               op_d  = DIVop;
               cnt_d = 5'd0;
               dvs_d = dvs_abs_s;
               if (divisor == 32'd0) begin
                  // Divide by zero: all-ones quotient, raw dividend as remainder
                  dvd_d   = 32'hFFFF_FFFF;
                  rem_d   = dividend;
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = S_READY;
               end else begin
                  dvd_d   = dvd_abs_s;
                  rem_d   = 32'd0;
                  qneg_d  = sd_s ^ ss_s;
                  rneg_d  = sd_s;
                  state_d = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (ge_s) begin
               rem_d = sub_s;
               dvd_d = {dvd_q[30:0], 1'b1};
            end else begin
               rem_d = rem_sh_s[31:0];
               dvd_d = {dvd_q[30:0], 1'b0};
            end
            if (cnt_q == 5'd31) begin
               state_d = S_READY;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_READY: begin
            result_d = op_q[1] ? rem_fix_s : quo_fix_s;
            ready_d  = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         dvd_q    <= 32'd0;
         dvs_q    <= 32'd0;
         rem_q    <= 32'd0;
         cnt_q    <= 5'd0;
         op_q     <= 2'd0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= 32'd0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result = result_q;
   assign ready  = ready_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider: hand-computed results and latencies.
module tb_divider;

   logic        clk;
   logic        resetn;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [1:0]  DIVop;
   logic        valid;
   logic [31:0] result;
   logic        ready;

   int n_tests;
   int n_fail;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   divider dut (
      .clk      (clk),
      .resetn   (resetn),
      .dividend (dividend),
      .divisor  (divisor),
      .DIVop    (DIVop),
      .valid    (valid),
      .result   (result),
      .ready    (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Wait (bounded) for a ready pulse; returns edges counted since the call
   task automatic wait_ready(output int lat, output logic got);
      lat = 0;
      got = 1'b0;
      while (lat < 60 && !got) begin
         @(posedge clk);
         lat++;
         #1;
         if (ready) got = 1'b1;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int   lat;
      logic got;
      logic [31:0] held;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      DIVop    = op;
      valid    = 1'b1;
      @(posedge clk);
      #1;
      dividend = $urandom;
      divisor  = $urandom;
      DIVop    = 2'($urandom_range(0, 3));
      valid    = 1'b0;
      wait_ready(lat, got);
      check_eq({tag, " ready seen"}, 32'(got), 32'd1);
      check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, " result"}, result, exp);
      held = result;
      @(posedge clk);
      #1;
      check_eq({tag, " ready pulse width"}, 32'(ready), 32'd0);
      check_eq({tag, " result hold"}, result, held);
   endtask

   initial begin
      int   lat;
      int   pulses;
      logic got;
      n_tests  = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      dividend = 32'd0;
      divisor  = 32'd0;
      DIVop    = 2'd0;
      valid    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset ready", 32'(ready), 32'd0);
      check_eq("reset result", result, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      run_op("DIV 20/-3",      OP_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
      run_op("REM 20%-3",      OP_REM,  32'd20,        32'hFFFF_FFFD, 32'h0000_0002, 33);
      run_op("REM -20%3",      OP_REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33);
      run_op("REMU ~0%16",     OP_REMU, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 33);
      run_op("DIVU ~0/0",      OP_DIVU, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1);
      run_op("REM 80000001%0", OP_REM,  32'h8000_0001, 32'd0,         32'h8000_0001, 1);
      run_op("DIV -7/0",       OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
      run_op("DIV ovf",        OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      run_op("REM ovf",        OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("DIVU hex",       OP_DIVU, 32'h1234_5678, 32'h0000_1000, 32'h0001_2345, 33);
      run_op("REMU hex",       OP_REMU, 32'h1234_5678, 32'h0000_1000, 32'h0000_0678, 33);
      run_op("DIV -100/7",     OP_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33);
      run_op("REM -100%7",     OP_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33);
      run_op("DIVU 5/7",       OP_DIVU, 32'd5,         32'd7,         32'h0000_0000, 33);
      run_op("DIVU ~0/1",      OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);
      run_op("DIV min/1",      OP_DIV,  32'h8000_0000, 32'd1,         32'h8000_0000, 33);
      run_op("DIVU big/bigger",OP_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("REMU big%bigger",OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

      // Abort mid-operation with reset; last result is nonzero so the clear is visible
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd3;
      DIVop    = OP_DIVU;
      valid    = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check_eq("abort ready", 32'(ready), 32'd0);
      check_eq("abort result", result, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready) pulses++;
      end
      check_eq("abort no pulse", 32'(pulses), 32'd0);
      run_op("DIVU 100/7 after abort", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

      // valid held across completion: exactly one extra op starts after the ready cycle
      @(negedge clk);
      dividend = 32'hFFFF_FFFF;
      divisor  = 32'd16;
      DIVop    = OP_REMU;
      valid    = 1'b1;
      @(posedge clk);
      #1;
      dividend = 32'd100;
      divisor  = 32'd7;
      DIVop    = OP_DIVU;
      wait_ready(lat, got);
      check_eq("held first ready", 32'(got), 32'd1);
      check_eq("held first latency", 32'(lat), 32'd33);
      check_eq("held first result", result, 32'h0000_000F);
      @(posedge clk);
      #1;
      check_eq("held ready drops", 32'(ready), 32'd0);
      @(posedge clk);
      #1;
      valid = 1'b0;
      wait_ready(lat, got);
      check_eq("held second ready", 32'(got), 32'd1);
      check_eq("held second latency", 32'(lat), 32'd33);
      check_eq("held second result", result, 32'd14);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready) pulses++;
      end
      check_eq("held no third op", 32'(pulses), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
